bpm_window_integrator: RTL and testbench
========================================

# bpm_window_integrator

- Downstream consumer of the 16-bit sample stream read back from the BPM circular sample buffer (one sample per `CLK` while `enable` is high).
- On a trigger pulse it skips a programmable number of samples, then sums a programmable window of samples.
- It presents the signed window sum to the readout logic on a valid/ready handshake.
- With baseline subtraction compiled in, a pre-delay window of equal length is summed first and subtracted, so the result is the pedestal-corrected electrode amplitude.

## Interface
Parameters:
- `DATA_W`, 16, sample width; samples are two's complement.
- `DLY_W`, 10, width of `cfg_delay`.
- `LEN_W`, 9, width of `cfg_len`; maximum window 511 samples.
- `SUM_W`, `DATA_W+LEN_W+1`, width of `sum_out`, signed.

Ports:
- `CLK` in 1: single clock for the whole block.
- `RST` in 1: reset, asynchronous, active-high.
- `dataAin` in `DATA_W`: sample from the circular buffer, signed.
- `enable` in 1: `dataAin` is a valid sample this cycle.
- `trigger` in 1: single-cycle trigger pulse.
- `cfg_delay` in `DLY_W`: samples skipped before the signal window.
- `cfg_len` in `LEN_W`: samples summed per window.
- `sum_out` out `SUM_W`: window result, signed.
- `out_valid` out 1: `sum_out` is valid.
- `out_ready` in 1: consumer accepts `sum_out`.
- `busy` out 1: block is in any state other than IDLE.
- `trig_miss` out 1: sticky; a trigger arrived while not IDLE.

## Operation
- States: IDLE, BASE, DELAY, INTEG, HOLD.
- IDLE + `trigger`:
  - latch `cfg_delay` and `cfg_len`; clear the accumulators.
  - go to BASE if baseline is enabled, else DELAY.
- Sample counting:
  - only cycles with `enable`=1 count as samples.
  - the sample present in the trigger cycle is never used.
- BASE: accumulate `cfg_len` samples into the baseline sum, then go to DELAY.
- DELAY: discard `cfg_delay` samples, then go to INTEG.
  - `cfg_delay`=0: DELAY is left immediately, with no sample consumed.
- INTEG: accumulate `cfg_len` samples into the signal sum, then go to HOLD.
- `cfg_len`=0:
  - BASE and INTEG are each left immediately with a sum of 0.
  - result is 0.
- HOLD:
  - `out_valid`=1; `sum_out` = signal sum − baseline sum, or the signal sum alone without baseline.
  - stays in HOLD until `out_valid`&`out_ready`, then returns to IDLE.
- Arithmetic:
  - samples are sign-extended to `SUM_W`.
  - the maximum window cannot overflow; no saturation logic.
- `trigger` in any non-IDLE state, including the HOLD transfer cycle:
  - ignored; `trig_miss` is set.
  - `trig_miss` is cleared only by `RST`.
- Config inputs are don't-care outside the trigger cycle.
- `enable` low stalls BASE, DELAY and INTEG indefinitely; there is no timeout.

## Timing
- Reset values:
  - state IDLE.
  - `sum_out`=0, `out_valid`=0, `busy`=0, `trig_miss`=0, accumulators 0.
- `RST` mid-operation aborts immediately; any pending result is lost.
- `busy` goes high the cycle after the trigger is accepted.
- `out_valid` rises the cycle after the last INTEG sample is accumulated: latency is 1 clock after that sample.
- `sum_out` is registered and stable while `out_valid`=1.
- `out_valid` falls the cycle after the transfer.
- A new trigger is accepted no earlier than the first IDLE cycle after the transfer.
- Immediate state exits (zero count) cost one clock per state, with no sample consumed.
- `out_ready` may be high before `out_valid`; the transfer then occurs in the first HOLD cycle.

## Configuration
- Macro `BPM_BASELINE_SUB_EN`.
- Defined:
  - BASE state and baseline accumulator present.
  - `sum_out` = signal − baseline.
  - trigger-to-result spans 2·`cfg_len`+`cfg_delay` samples.
- Undefined:
  - BASE state and baseline register removed; IDLE goes directly to DELAY.
  - `sum_out` = signal sum.
  - port list and widths unchanged.

## Structure
- Shared package `bpm_pkg`: state enum, default `DATA_W`/`DLY_W`/`LEN_W`, derived `SUM_W`.
- One sub-module, `bpm_sample_counter`:
  - loadable down-counter, decremented on `enable`.
  - flags `zero`.
  - instantiated once and reloaded on entry to each of BASE, DELAY and INTEG.

## Test plan
- Reset, then `cfg_delay`=2, `cfg_len`=4, stream 1..10 with `enable` always high, trigger before sample 1:
  - without baseline, `sum_out`=3+4+5+6=18.
  - with baseline, (7+8+9+10)−(1+2+3+4)=24.
- `enable` toggling every other cycle during the same run: identical result; `out_valid` arrives correspondingly later.
- `cfg_len`=511, constant input −32768, `cfg_delay`=0:
  - without baseline, `sum_out`=−16744448.
  - with baseline, 0.
- `out_ready` low for 20 cycles in HOLD, trigger pulsed during HOLD:
  - `sum_out` held stable; `trig_miss`=1.
  - no second result after the transfer.
- `cfg_len`=0, `cfg_delay`=0: `out_valid` with `sum_out`=0 within 4 clocks of the trigger, no samples consumed.
- `RST` asserted during INTEG:
  - outputs return to reset values asynchronously.
  - the next trigger produces a correct fresh sum.

Source files
------------

// File: rtl/bpm_pkg.sv
// Shared definitions for the BPM window integrator: FSM state encoding and default widths.
package bpm_pkg;

    localparam int BPM_DATA_W = 16;
    localparam int BPM_DLY_W  = 10;
    localparam int BPM_LEN_W  = 9;
    localparam int BPM_SUM_W  = BPM_DATA_W + BPM_LEN_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BASE,
        ST_DELAY,
        ST_INTEG,
        ST_HOLD
    } bpm_state_e;

endpackage

// File: rtl/bpm_sample_counter.sv
// Loadable down-counter of valid samples; load wins over decrement, saturates at zero.
module bpm_sample_counter
    import bpm_pkg::*;
#(
    parameter int CNT_W = 10
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o,
    output logic             one_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);
    assign one_o  = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/bpm_window_integrator.sv
// Triggered delay-then-window integrator of the BPM sample stream with a valid/ready result.
// Define BPM_BASELINE_SUB_EN to sum an equal-length pre-delay window and subtract it.
module bpm_window_integrator
    import bpm_pkg::*;
#(
    parameter int DATA_W = BPM_DATA_W,
    parameter int DLY_W  = BPM_DLY_W,
    parameter int LEN_W  = BPM_LEN_W,
    parameter int SUM_W  = DATA_W + LEN_W + 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] dataAin,
    input  logic              enable,
    input  logic              trigger,
    input  logic [DLY_W-1:0]  cfg_delay,
    input  logic [LEN_W-1:0]  cfg_len,
    output logic [SUM_W-1:0]  sum_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              trig_miss
);

    localparam int CNT_W = (DLY_W > LEN_W) ? DLY_W : LEN_W;

    bpm_state_e              state_q;
    logic [LEN_W-1:0]        len_q;
    logic signed [SUM_W-1:0] sig_acc_q;
    logic [SUM_W-1:0]        sum_out_q;
    logic                    out_valid_q;
    logic                    busy_q;
    logic                    trig_miss_q;
`ifdef BPM_BASELINE_SUB_EN
    logic [DLY_W-1:0]        dly_q;
    logic signed [SUM_W-1:0] base_acc_q;
`endif

    logic signed [SUM_W-1:0] samp_ext;
    logic signed [SUM_W-1:0] sig_acc_nxt;
    logic                    cnt_load;
    logic [CNT_W-1:0]        cnt_val;
    logic                    cnt_zero;
    logic                    cnt_one;
    logic                    smp_use;
    logic                    st_done;

    assign samp_ext = {{(SUM_W-DATA_W){dataAin[DATA_W-1]}}, dataAin};

    // A counting state exits on its last sample, or at once if its count was zero.
    assign smp_use     = enable && !cnt_zero;
    assign st_done     = cnt_zero || (enable && cnt_one);
    assign sig_acc_nxt = smp_use ? (sig_acc_q + samp_ext) : sig_acc_q;

    // Counter is reloaded in the same cycle the FSM enters the next counting state.
    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = '0;
        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    cnt_load = 1'b1;
`ifdef BPM_BASELINE_SUB_EN
                    cnt_val  = CNT_W'(cfg_len);
`else
                    cnt_val  = CNT_W'(cfg_delay);
`endif
                end
            end
`ifdef BPM_BASELINE_SUB_EN
            ST_BASE: begin
                if (st_done) begin
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(dly_q);
                end
            end
`endif
            ST_DELAY: begin
                if (st_done) begin
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(len_q);
                end
            end
            default: ;
        endcase
    end

    bpm_sample_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .CLK        (CLK),
        .RST        (RST),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .dec_i      (enable),
        .zero_o     (cnt_zero),
        .one_o      (cnt_one)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            sig_acc_q   <= '0;
            sum_out_q   <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            trig_miss_q <= 1'b0;
`ifdef BPM_BASELINE_SUB_EN
            dly_q       <= '0;
            base_acc_q  <= '0;
`endif
        end else begin
            if (trigger && (state_q != ST_IDLE)) begin
                trig_miss_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (trigger) begin
                        len_q     <= cfg_len;
                        sig_acc_q <= '0;
                        busy_q    <= 1'b1;
`ifdef BPM_BASELINE_SUB_EN
                        dly_q      <= cfg_delay;
                        base_acc_q <= '0;
                        state_q    <= ST_BASE;
`else
                        state_q    <= ST_DELAY;
`endif
                    end
                end
`ifdef BPM_BASELINE_SUB_EN
                ST_BASE: begin
                    if (smp_use) begin
                        base_acc_q <= base_acc_q + samp_ext;
                    end
                    if (st_done) begin
                        state_q <= ST_DELAY;
                    end
                end
`endif
                ST_DELAY: begin
                    if (st_done) begin
                        state_q <= ST_INTEG;
                    end
                end
                ST_INTEG: begin
                    sig_acc_q <= sig_acc_nxt;
                    if (st_done) begin
                        state_q     <= ST_HOLD;
                        out_valid_q <= 1'b1;
`ifdef BPM_BASELINE_SUB_EN
                        sum_out_q   <= sig_acc_nxt - base_acc_q;
`else
                        sum_out_q   <= sig_acc_nxt;
`endif
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign sum_out   = sum_out_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign trig_miss = trig_miss_q;

endmodule

// File: tb/tb_bpm_window_integrator.sv
// Scoreboard bench for bpm_window_integrator; expected sums follow BPM_BASELINE_SUB_EN.
module tb_bpm_window_integrator;

    localparam int DATA_W = 16;
    localparam int DLY_W  = 10;
    localparam int LEN_W  = 9;
    localparam int SUM_W  = DATA_W + LEN_W + 1;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic [DATA_W-1:0] dataAin = '0;
    logic              enable = 1'b0;
    logic              trigger = 1'b0;
    logic [DLY_W-1:0]  cfg_delay = '0;
    logic [LEN_W-1:0]  cfg_len = '0;
    logic [SUM_W-1:0]  sum_out;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic              busy;
    logic              trig_miss;

    int     n_checks = 0;
    int     n_fail   = 0;
    longint exp_q[$];

    bpm_window_integrator dut (
        .CLK       (CLK),
        .RST       (RST),
        .dataAin   (dataAin),
        .enable    (enable),
        .trigger   (trigger),
        .cfg_delay (cfg_delay),
        .cfg_len   (cfg_len),
        .sum_out   (sum_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .trig_miss (trig_miss)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string nm, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    function automatic logic [DATA_W-1:0] sample(input int mode, input int k);
        case (mode)
            0:       return DATA_W'(k);
            1:       return 16'h8000;
            default: return DATA_W'(k * 10);
        endcase
    endfunction

    // Result monitor: every accepted transfer must match the oldest queued expectation.
    initial begin
        longint e;
        forever begin
            @(negedge CLK);
            #2;
            if (!RST && out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_result: got sum_out=%0d, required no result",
                             $signed(sum_out));
                end else begin
                    e = exp_q.pop_front();
                    if (longint'($signed(sum_out)) != e) begin
                        n_fail++;
                        $display("FAIL result: got sum_out=%0d, required %0d", $signed(sum_out), e);
                    end else begin
                        $display("result sum_out=%0d ok at %0t", $signed(sum_out), $time);
                    end
                end
            end
        end
    end

    // One trigger plus n streamed cycles; out_valid must rise right after cycle n.
    task automatic run_txn(input string nm, input int dly, input int len, input int mode,
                           input bit gaps, input int n, input longint exp, input int abort_at);
        @(negedge CLK);
        cfg_delay = DLY_W'(dly);
        cfg_len   = LEN_W'(len);
        trigger   = 1'b1;
        enable    = 1'b1;
        dataAin   = 16'h0555;
        if (abort_at < 0) exp_q.push_back(exp);
        @(negedge CLK);
        trigger   = 1'b0;
        cfg_delay = DLY_W'($urandom);
        cfg_len   = LEN_W'($urandom);
        check({nm, "_busy_after_trig"}, longint'(busy), 1);
        for (int k = 1; k <= n; k++) begin
            if (gaps) begin
                enable  = 1'b0;
                dataAin = 16'h1234;
                @(negedge CLK);
            end
            enable  = 1'b1;
            dataAin = sample(mode, k);
            @(negedge CLK);
            if (k == abort_at) begin
                #1 RST = 1'b1;
                #1;
                check({nm, "_rst_sum"},       longint'(sum_out),   0);
                check({nm, "_rst_valid"},     longint'(out_valid), 0);
                check({nm, "_rst_busy"},      longint'(busy),      0);
                check({nm, "_rst_trig_miss"}, longint'(trig_miss), 0);
                enable = 1'b0;
                @(negedge CLK);
                RST = 1'b0;
                $display("txn %s aborted by reset", nm);
                return;
            end
            if (k == n - 1) check({nm, "_valid_early"}, longint'(out_valid), 0);
            if (k == n)     check({nm, "_valid_latency"}, longint'(out_valid), 1);
        end
        enable = 1'b0;
        $display("txn %s issued: delay=%0d len=%0d expect=%0d", nm, dly, len, exp);
    endtask

    task automatic wait_idle(input string nm);
        int i;
        i = 0;
        while ((busy || out_valid) && (i < 3000)) begin
            @(negedge CLK);
            i++;
        end
        check({nm, "_idle_timeout"}, longint'(busy || out_valid), 0);
    endtask

    initial begin
`ifdef BPM_BASELINE_SUB_EN
        localparam bit BL = 1'b1;
`else
        localparam bit BL = 1'b0;
`endif
        repeat (3) @(negedge CLK);
        check("reset_sum",       longint'(sum_out),   0);
        check("reset_valid",     longint'(out_valid), 0);
        check("reset_busy",      longint'(busy),      0);
        check("reset_trig_miss", longint'(trig_miss), 0);
        RST = 1'b0;
        @(negedge CLK);
        check("post_reset_busy", longint'(busy), 0);

        // Delay 2, len 4, samples 1..10.
        run_txn("basic", 2, 4, 0, 1'b0, BL ? 10 : 6, BL ? 64'sd24 : 64'sd18, -1);
        wait_idle("basic");
        check("basic_no_miss", longint'(trig_miss), 0);

        run_txn("gaps", 2, 4, 0, 1'b1, BL ? 10 : 6, BL ? 64'sd24 : 64'sd18, -1);
        wait_idle("gaps");

        // Full-scale negative window, zero delay (one non-consuming DELAY cycle).
        run_txn("maxwin", 0, 511, 1, 1'b0, BL ? 1023 : 512, BL ? 64'sd0 : -64'sd16744448, -1);
        wait_idle("maxwin");

        run_txn("zero_len", 0, 0, 2, 1'b0, BL ? 3 : 2, 64'sd0, -1);
        wait_idle("zero_len");

        // Back-pressure in HOLD with a trigger that must be ignored.
        out_ready = 1'b0;
        run_txn("hold", 1, 3, 2, 1'b0, BL ? 7 : 4, BL ? 64'sd120 : 64'sd90, -1);
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            check("hold_valid", longint'(out_valid), 1);
            check("hold_sum", longint'($signed(sum_out)), BL ? 64'sd120 : 64'sd90);
            trigger = (i == 5);
        end
        @(negedge CLK);
        trigger = 1'b0;
        check("hold_trig_miss", longint'(trig_miss), 1);
        out_ready = 1'b1;
        wait_idle("hold");
        repeat (10) @(negedge CLK);
        check("hold_no_second_busy", longint'(busy), 0);

        // Reset during INTEG, then a fresh window.
        run_txn("abort", 2, 4, 0, 1'b0, BL ? 10 : 6, 64'sd0, BL ? 8 : 4);
        run_txn("fresh", 2, 4, 0, 1'b0, BL ? 10 : 6, BL ? 64'sd24 : 64'sd18, -1);
        wait_idle("fresh");

        repeat (3) @(negedge CLK);
        check("scoreboard_drained", longint'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
